otp_prog_sequencer: RTL and testbench
=====================================

# otp_prog_sequencer

Command sequencer directly upstream of the OTP array controller FSM. It accepts read/program commands over a valid/ready handshake and drives the FSM's `mode`, `column` and `data_in`. Programs are verified by read-back, with optional retries. It then returns a response carrying read data and pass/fail status, and drives `writing_successful` into the FSM.

## Interface
- `A`, 5, word width (rows of the array)
- `B`, 5, number of columns
- `ADDR_WIDTH`, `$clog2(B)`, column address width
- `WRITE_WAIT`, 16, cycles a program pulse is allowed to settle after issue
- `READ_TIMEOUT`, 32, max cycles to wait for `fsm_read_active` to rise, and again to fall
- `MAX_RETRY`, 3, extra program attempts after the first (only with retry compiled in)

Ports (name, direction, width, meaning):
- `clk` in 1 — single clock, all logic rising-edge
- `reset` in 1 — asynchronous, active-low
- `cmd_valid` in 1 — command present
- `cmd_ready` out 1 — sequencer accepts a command
- `cmd_write` in 1 — 1 = program, 0 = read
- `cmd_column` in ADDR_WIDTH — target column
- `cmd_data` in A — bits to program (1 = program cell)
- `rsp_valid` out 1 — response present
- `rsp_ready` in 1 — consumer takes response
- `rsp_data` out A — read-back word
- `rsp_ok` out 1 — command succeeded
- `rsp_attempts` out 3 — program pulses issued (0 for reads/rejects)
- `mode` out 2 — to FSM: 00 read, 01 write, 10 idle
- `column` out ADDR_WIDTH — to FSM
- `data_in` out A — to FSM
- `writing_successful` out 1 — to FSM, latest verify result
- `fsm_read_active` in 1 — FSM read in progress
- `fsm_data_out` in A — FSM read data

## Operation
- States: IDLE, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD_START, WAIT_RD_END, CHECK, RESPOND.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid&&cmd_ready`, latch column, data and write flag.
  - Column ≥ B → RESPOND with `rsp_ok`=0, `rsp_data`=0, `rsp_attempts`=0. No FSM traffic.
  - Otherwise → ISSUE_WR (write) or ISSUE_RD (read).
- ISSUE_WR:
  - `mode`=01 for exactly one cycle, with `column`/`data_in` from latched values.
  - Increment attempts.
  - Load the timer with WRITE_WAIT → WAIT_WR.
- WAIT_WR: `mode`=10. On timer expiry → ISSUE_RD.
- ISSUE_RD: `mode`=00 for one cycle → WAIT_RD_START (timer = READ_TIMEOUT).
- WAIT_RD_START:
  - `fsm_read_active` rises → WAIT_RD_END (timer reload).
  - Timeout → RESPOND with `rsp_ok`=0.
- WAIT_RD_END:
  - On falling `fsm_read_active`, sample `fsm_data_out` into `rsp_data` → CHECK.
  - Timeout → RESPOND with `rsp_ok`=0.
- CHECK:
  - Read command: `rsp_ok`=1 → RESPOND.
  - Write command: pass iff `(rsp_data & data) == data`. Extra 1s in the read-back are not a failure.
  - `writing_successful` is updated with the result in this cycle and holds until the next CHECK.
  - Pass → RESPOND with `rsp_ok`=1.
  - Fail with retry available → reprogram, setting `data_in` = `data & ~rsp_data` (failing bits only) → ISSUE_WR.
  - Fail with no retry left → RESPOND with `rsp_ok`=0.
- RESPOND:
  - `rsp_valid`=1; `rsp_data`/`rsp_ok`/`rsp_attempts` stable.
  - On `rsp_ready` → IDLE.
- `mode` is 10 in every state except ISSUE_WR and ISSUE_RD.

## Timing
- Reset values:
  - `mode`=10; `column`=0; `data_in`=0; `writing_successful`=1.
  - `cmd_ready`=0 during reset, 1 on the first cycle after release.
  - `rsp_valid`=0; `rsp_data`=0; `rsp_ok`=0; `rsp_attempts`=0.
- Reset asserted mid-operation aborts immediately to IDLE with reset values. A pending response is lost.
- Command accept to `mode` issue: 1 cycle.
- Read latency: 2 + FSM read duration + 1 (CHECK) cycles to `rsp_valid`.
- Write, single attempt: 1 + 1 + WRITE_WAIT + read path.
- The timer counts down to 0; expiry is the cycle the count is 0.
- `cmd_ready` is 0 in every state except IDLE. There is no command pipelining.
- `rsp_valid` must not drop and response fields must not change until `rsp_ready` is seen.
- `fsm_read_active` already high on entry to WAIT_RD_START counts as a rise.
- Attempt count saturates at 7.

## Configuration
- `OTP_SEQ_RETRY_EN` defined:
  - On verify failure, up to MAX_RETRY further program pulses, masked to failing bits.
  - `rsp_attempts` ranges 1..MAX_RETRY+1.
- Not defined:
  - A failed verify goes straight to RESPOND with `rsp_ok`=0.
  - `rsp_attempts` is always 1 for writes, and MAX_RETRY is ignored.

## Structure
- Shared package `otp_pkg`:
  - Mode encodings (`MODE_READING`=00, `MODE_WRITING`=01, `MODE_IDLE`=10).
  - `WRITING_SUCCESSFUL`/`WRITING_NOT_SUCCESSFUL`.
  - The sequencer state enum.
- One sub-module `otp_cycle_timer`: loadable down-counter with `load`, `load_value`, `expired`.

## Test plan
- Read column 2 with the FSM model returning 5'b10110 → `mode`=00 for one cycle, `column`=2; `rsp_data`=10110, `rsp_ok`=1, `rsp_attempts`=0.
- Write 5'b00011 to column 1, model reads back 00011 → one write pulse, `writing_successful`=1, `rsp_ok`=1, `rsp_attempts`=1.
- With `OTP_SEQ_RETRY_EN`: write 5'b00111, first read-back 00101, second 00111 → second pulse has `data_in`=00010; `rsp_ok`=1, `rsp_attempts`=2.
- With `OTP_SEQ_RETRY_EN`: write 5'b00001, read-back always 0 → 4 pulses, `rsp_ok`=0, `rsp_attempts`=4, `writing_successful`=0.
- Command with column 7 (B=5) → no `mode` change, `rsp_ok`=0, response within 2 cycles.
- Read where `fsm_read_active` never rises → `rsp_ok`=0 after 32 cycles. Then assert `reset` low during a later write → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/otp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : otp_pkg
// Brief    : FSM mode encodings, verify flags and sequencer state type.
// Revision : 1.0 - initial release
// ============================================================================
package otp_pkg;

  localparam logic [1:0] MODE_READING = 2'b00;
  localparam logic [1:0] MODE_WRITING = 2'b01;
  localparam logic [1:0] MODE_IDLE    = 2'b10;

  localparam logic WRITING_SUCCESSFUL     = 1'b1;
  localparam logic WRITING_NOT_SUCCESSFUL = 1'b0;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    ISSUE_WR      = 3'd1,
    WAIT_WR       = 3'd2,
    ISSUE_RD      = 3'd3,
    WAIT_RD_START = 3'd4,
    WAIT_RD_END   = 3'd5,
    CHECK         = 3'd6,
    RESPOND       = 3'd7
  } seq_state_t;

  // Pulse counter stops at 7 rather than wrapping.
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/otp_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : otp_cycle_timer
// Brief    : Loadable down-counter; expired while the count sits at zero.
// Revision : 1.0 - initial release
// ============================================================================
module otp_cycle_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/otp_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : otp_prog_sequencer
// Brief    : Read/program command sequencer with read-back verify in front
//            of the OTP array FSM. Define OTP_SEQ_RETRY_EN for masked retries.
// Revision : 1.0 - initial release
// ============================================================================
module otp_prog_sequencer
  import otp_pkg::*;
#(
  parameter int A            = 5,
  parameter int B            = 5,
  parameter int ADDR_WIDTH   = $clog2(B),
  parameter int WRITE_WAIT   = 16,
  parameter int READ_TIMEOUT = 32,
  parameter int MAX_RETRY    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_column,
  input  logic [A-1:0]          cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [A-1:0]          rsp_data,
  output logic                  rsp_ok,
  output logic [2:0]            rsp_attempts,
  output logic [1:0]            mode,
  output logic [ADDR_WIDTH-1:0] column,
  output logic [A-1:0]          data_in,
  output logic                  writing_successful,
  input  logic                  fsm_read_active,
  input  logic [A-1:0]          fsm_data_out
);

  localparam int c_timer_max = (WRITE_WAIT > READ_TIMEOUT) ? WRITE_WAIT : READ_TIMEOUT;
  localparam int c_timer_w   = $clog2(c_timer_max + 1);
  localparam logic [c_timer_w-1:0]  c_write_wait   = c_timer_w'(WRITE_WAIT);
  localparam logic [c_timer_w-1:0]  c_read_timeout = c_timer_w'(READ_TIMEOUT);
  localparam logic [ADDR_WIDTH:0]   c_cols         = (ADDR_WIDTH + 1)'(B);

`ifdef OTP_SEQ_RETRY_EN
  localparam int c_max_attempts = (MAX_RETRY + 1 > 7) ? 7 : MAX_RETRY + 1;
`else
  // Single pulse per write; the retry budget has no effect in this build.
  localparam int c_max_attempts = (MAX_RETRY >= 0) ? 1 : 1;
`endif

  seq_state_t            r_state;
  logic                  r_wr;
  logic [A-1:0]          r_data;
  logic                  r_cmd_ready;
  logic                  r_rsp_valid;
  logic [A-1:0]          r_rsp_data;
  logic                  r_rsp_ok;
  logic [2:0]            r_rsp_attempts;
  logic [1:0]            r_mode;
  logic [ADDR_WIDTH-1:0] r_column;
  logic [A-1:0]          r_data_in;
  logic                  r_writing_successful;

  logic                  w_timer_load;
  logic [c_timer_w-1:0]  w_timer_value;
  logic                  w_timer_expired;
  logic                  w_pass;
  logic                  w_retry_left;

  assign w_timer_load  = (r_state == ISSUE_WR) || (r_state == ISSUE_RD) ||
                         ((r_state == WAIT_RD_START) && fsm_read_active);
  assign w_timer_value = (r_state == ISSUE_WR) ? c_write_wait : c_read_timeout;
  assign w_pass        = ((r_rsp_data & r_data) == r_data);
  assign w_retry_left  = (int'(r_rsp_attempts) < c_max_attempts);

  otp_cycle_timer #(
    .WIDTH (c_timer_w)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (w_timer_load),
    .load_value (w_timer_value),
    .expired    (w_timer_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state              <= IDLE;
      r_wr                 <= 1'b0;
      r_data               <= '0;
      r_cmd_ready          <= 1'b0;
      r_rsp_valid          <= 1'b0;
      r_rsp_data           <= '0;
      r_rsp_ok             <= 1'b0;
      r_rsp_attempts       <= 3'd0;
      r_mode               <= MODE_IDLE;
      r_column             <= '0;
      r_data_in            <= '0;
      r_writing_successful <= WRITING_SUCCESSFUL;
    end else begin
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready    <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_ok       <= 1'b0;
            r_rsp_attempts <= 3'd0;
            r_wr           <= cmd_write;
            r_data         <= cmd_data;
            if ({1'b0, cmd_column} >= c_cols) begin
              r_rsp_valid <= 1'b1;
              r_state     <= RESPOND;
            end else begin
              r_column <= cmd_column;
              if (cmd_write) begin
                r_data_in <= cmd_data;
                r_mode    <= MODE_WRITING;
                r_state   <= ISSUE_WR;
              end else begin
                r_mode  <= MODE_READING;
                r_state <= ISSUE_RD;
              end
            end
          end
        end
        ISSUE_WR: begin
          r_mode         <= MODE_IDLE;
          r_rsp_attempts <= sat_inc3(r_rsp_attempts);
          r_state        <= WAIT_WR;
        end
        WAIT_WR: begin
          if (w_timer_expired) begin
            r_mode  <= MODE_READING;
            r_state <= ISSUE_RD;
          end
        end
        ISSUE_RD: begin
          r_mode  <= MODE_IDLE;
          r_state <= WAIT_RD_START;
        end
        WAIT_RD_START: begin
          if (fsm_read_active) begin
            r_state <= WAIT_RD_END;
          end else if (w_timer_expired) begin
            r_rsp_ok    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESPOND;
          end
        end
        WAIT_RD_END: begin
          if (!fsm_read_active) begin
            r_rsp_data <= fsm_data_out;
            r_state    <= CHECK;
          end else if (w_timer_expired) begin
            r_rsp_ok    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESPOND;
          end
        end
        CHECK: begin
          if (!r_wr) begin
            r_rsp_ok    <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= RESPOND;
          end else begin
            r_writing_successful <= w_pass ? WRITING_SUCCESSFUL : WRITING_NOT_SUCCESSFUL;
            if (w_pass) begin
              r_rsp_ok    <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= RESPOND;
            end else if (w_retry_left) begin
              // Re-pulse only the cells that did not read back as programmed.
              r_data_in <= r_data & ~r_rsp_data;
              r_mode    <= MODE_WRITING;
              r_state   <= ISSUE_WR;
            end else begin
              r_rsp_ok    <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_state     <= RESPOND;
            end
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_mode  <= MODE_IDLE;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready          = r_cmd_ready;
  assign rsp_valid          = r_rsp_valid;
  assign rsp_data           = r_rsp_data;
  assign rsp_ok             = r_rsp_ok;
  assign rsp_attempts       = r_rsp_attempts;
  assign mode               = r_mode;
  assign column             = r_column;
  assign data_in            = r_data_in;
  assign writing_successful = r_writing_successful;

endmodule
`default_nettype wire

// File: tb/tb_otp_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_otp_prog_sequencer
// Brief    : Scoreboard bench with a behavioural OTP FSM read model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_otp_prog_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [2:0] cmd_column;
  logic [4:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_data;
  logic       rsp_ok;
  logic [2:0] rsp_attempts;
  logic [1:0] mode;
  logic [2:0] column;
  logic [4:0] data_in;
  logic       writing_successful;
  logic       fsm_read_active;
  logic [4:0] fsm_data_out;

  typedef struct packed {
    logic [4:0] data;
    logic       ok;
    logic [2:0] att;
  } rsp_t;

  rsp_t       exp_q[$];
  logic [4:0] rb_q[$];
  logic [4:0] wr_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_rd_cyc = 0;
  logic [2:0] last_rd_col = 3'd0;
  logic       model_dead = 1'b0;

  otp_prog_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_write          (cmd_write),
    .cmd_column         (cmd_column),
    .cmd_data           (cmd_data),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_data           (rsp_data),
    .rsp_ok             (rsp_ok),
    .rsp_attempts       (rsp_attempts),
    .mode               (mode),
    .column             (column),
    .data_in            (data_in),
    .writing_successful (writing_successful),
    .fsm_read_active    (fsm_read_active),
    .fsm_data_out       (fsm_data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every response the DUT hands over.
  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_ok", 32'(rsp_ok), 32'(e.ok));
        check("rsp_attempts", 32'(rsp_attempts), 32'(e.att));
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (mode == 2'b00) begin
        n_rd_cyc++;
        last_rd_col = column;
      end
      if (mode == 2'b01) wr_q.push_back(data_in);
    end
  end

  // FSM read model: two cycles after a read request, active for three cycles.
  initial begin
    fsm_read_active = 1'b0;
    fsm_data_out    = 5'd0;
    forever begin
      @(negedge clk);
      if (reset && mode == 2'b00 && !model_dead) begin
        logic [4:0] d;
        d = (rb_q.size() != 0) ? rb_q.pop_front() : 5'd0;
        repeat (2) @(negedge clk);
        fsm_read_active = 1'b1;
        fsm_data_out    = d;
        repeat (3) @(negedge clk);
        fsm_read_active = 1'b0;
      end
    end
  end

  task automatic send(input logic w, input logic [2:0] col, input logic [4:0] d);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_write  = w;
    cmd_column = col;
    cmd_data   = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("rsp_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic run_cmd(input logic w, input logic [2:0] col, input logic [4:0] d,
                         input logic [4:0] ed, input logic eok, input logic [2:0] ea);
    exp_q.push_back('{data: ed, ok: eok, att: ea});
    send(w, col, d);
    wait_drain();
  endtask

  task automatic check_reset_values();
    check("rst_mode", 32'(mode), 32'h2);
    check("rst_column", 32'(column), 32'd0);
    check("rst_data_in", 32'(data_in), 32'd0);
    check("rst_ws", 32'(writing_successful), 32'd1);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_ok", 32'(rsp_ok), 32'd0);
    check("rst_rsp_att", 32'(rsp_attempts), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n_rd0;
    int n;
    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_column = 3'd0;
    cmd_data   = 5'd0;
    rsp_ready  = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_reset_values();
    reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Read column 2
    n_rd0 = n_rd_cyc;
    wr_q.delete();
    rb_q.push_back(5'b10110);
    run_cmd(1'b0, 3'd2, 5'd0, 5'b10110, 1'b1, 3'd0);
    check("read_mode_cycles", 32'(n_rd_cyc - n_rd0), 32'd1);
    check("read_column", 32'(last_rd_col), 32'd2);
    check("read_no_wr", 32'(wr_q.size()), 32'd0);

    // Single-attempt write that verifies
    wr_q.delete();
    rb_q.push_back(5'b00011);
    run_cmd(1'b1, 3'd1, 5'b00011, 5'b00011, 1'b1, 3'd1);
    check("wr_pulses", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() > 0) check("wr_pulse_data", 32'(wr_q[0]), 32'h03);
    check("wr_ws", 32'(writing_successful), 32'd1);

    // Extra ones in the read-back still pass
    wr_q.delete();
    rb_q.push_back(5'b00111);
    run_cmd(1'b1, 3'd0, 5'b00001, 5'b00111, 1'b1, 3'd1);
    check("extra1_pulses", 32'(wr_q.size()), 32'd1);

`ifdef OTP_SEQ_RETRY_EN
    wr_q.delete();
    rb_q.push_back(5'b00101);
    rb_q.push_back(5'b00111);
    run_cmd(1'b1, 3'd3, 5'b00111, 5'b00111, 1'b1, 3'd2);
    check("retry_pulses", 32'(wr_q.size()), 32'd2);
    if (wr_q.size() > 1) check("retry_mask", 32'(wr_q[1]), 32'h02);

    wr_q.delete();
    rb_q.delete();
    run_cmd(1'b1, 3'd4, 5'b00001, 5'b00000, 1'b0, 3'd4);
    check("exhaust_pulses", 32'(wr_q.size()), 32'd4);
    check("exhaust_ws", 32'(writing_successful), 32'd0);
`else
    wr_q.delete();
    rb_q.push_back(5'b00101);
    run_cmd(1'b1, 3'd3, 5'b00111, 5'b00101, 1'b0, 3'd1);
    check("fail_pulses", 32'(wr_q.size()), 32'd1);
    check("fail_ws", 32'(writing_successful), 32'd0);
`endif

    // Out-of-range column, response held while not ready
    n_rd0 = n_rd_cyc;
    wr_q.delete();
    rsp_ready = 1'b0;
    exp_q.push_back('{data: 5'd0, ok: 1'b0, att: 3'd0});
    send(1'b0, 3'd7, 5'd0);
    n = 0;
    while (!rsp_valid && n < 2) begin
      @(posedge clk); #1;
      n++;
    end
    check("badcol_rsp_valid", 32'(rsp_valid), 32'd1);
    repeat (3) @(posedge clk); #1;
    check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
    check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    wait_drain();
    check("badcol_no_rd", 32'(n_rd_cyc - n_rd0), 32'd0);
    check("badcol_no_wr", 32'(wr_q.size()), 32'd0);

    // Read that never starts
    n_rd0 = n_rd_cyc;
    model_dead = 1'b1;
    run_cmd(1'b0, 3'd3, 5'd0, 5'd0, 1'b0, 3'd0);
    model_dead = 1'b0;
    check("timeout_rd_cycles", 32'(n_rd_cyc - n_rd0), 32'd1);

    // Asynchronous reset in the middle of a write
    wr_q.delete();
    send(1'b1, 3'd4, 5'b11111);
    n = 0;
    while (wr_q.size() == 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("midwr_pulse_seen", 32'(wr_q.size()), 32'd1);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_reset_values();
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst2", 32'(cmd_ready), 32'd1);

    rb_q.push_back(5'b01001);
    run_cmd(1'b0, 3'd4, 5'd0, 5'b01001, 1'b1, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
